raster_sram_writer: RTL and testbench
=====================================

RASTER_SRAM_WRITER -- requirements
Module: raster_sram_writer

Interface
REQ-001 SHALL have parameter H_RES, 640, frame width in pixels.
REQ-002 SHALL have parameter V_RES, 480, frame height in pixels.
REQ-003 SHALL have parameter ADDR_W, 20, SRAM word-address width.
REQ-004 SHALL have parameter DATA_W, 16, SRAM/pixel data width.
REQ-005 SHALL have parameter FIFO_DEPTH, 8, pixel buffer entries (power of 2, >=2).
REQ-006 SHALL have parameter WAIT_CYC, 2, cycles o_sram_we_n is held low per write (>=1).
REQ-007 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 i_pix_valid  in  1  pixel write request.
REQ-010 o_pix_ready  out  1  pixel accepted when valid&ready at a clk edge.
REQ-011 i_pix_x  in  10  pixel column; i_pix_y  in  9  pixel row; i_pix_data  in  DATA_W  pixel value.
REQ-012 i_clear_start  in  1  one-cycle request to fill frame with i_clear_data.
REQ-013 i_clear_data  in  DATA_W  fill value, sampled with i_clear_start.
REQ-014 o_idle  out  1  FIFO empty and FSM in IDLE.
REQ-015 o_done  out  1  one-cycle pulse at clear completion.
REQ-016 o_drop_cnt  out  16  saturating count of out-of-range pixels.
REQ-017 o_sram_addr  out  ADDR_W; io_sram_data  inout  DATA_W; o_sram_we_n  out  1; o_sram_oe_n  out  1.

Function
REQ-018 Accepted pixel with x<H_RES and y<V_RES SHALL be pushed into FIFO as {addr=y*H_RES+x truncated to ADDR_W, data}.
REQ-019 Accepted pixel out of range SHALL NOT be pushed; o_drop_cnt SHALL increment, saturating at 16'hFFFF.
REQ-020 o_pix_ready SHALL be high iff FIFO not full and FSM not in CLEAR; push and pop in same cycle SHALL both occur.
REQ-021 FSM states: IDLE, WRITE, RECOVER, CLEAR_WR, CLEAR_REC.
REQ-022 IDLE->WRITE when FIFO non-empty (pop, latch addr/data); IDLE->CLEAR_WR when i_clear_start and FIFO empty; pixel drain SHALL take priority, i_clear_start otherwise ignored.
REQ-023 WRITE/CLEAR_WR: o_sram_we_n low for exactly WAIT_CYC cycles, addr/data stable, then RECOVER/CLEAR_REC for 1 cycle with we_n high, addr/data held.
REQ-024 RECOVER->WRITE if FIFO non-empty (back-to-back, pop), else IDLE; each write SHALL occupy WAIT_CYC+1 cycles.
REQ-025 CLEAR_REC SHALL increment clear address; after address H_RES*V_RES-1 SHALL go IDLE and pulse o_done the same cycle IDLE is entered.
REQ-026 io_sram_data SHALL be driven only in WRITE, RECOVER, CLEAR_WR, CLEAR_REC; high-Z otherwise.
REQ-027 o_sram_oe_n SHALL be constantly high (write-only block).
REQ-028 o_idle SHALL be low from the cycle after any accept or clear start until drain/clear completes.

Reset
REQ-029 On rst low, immediately: we_n=1, oe_n=1, io_sram_data high-Z, o_sram_addr=0, o_pix_ready=0, o_done=0, o_idle=0, o_drop_cnt=0, FIFO emptied, FSM IDLE.
REQ-030 After rst release o_pix_ready and o_idle SHALL be 1 from the first clk edge; reset mid-write SHALL abandon the write without completing it.

Structure
REQ-031 FSM state encoding and default H_RES/V_RES/ADDR_W/DATA_W constants SHALL live in shared package raster_pkg.
REQ-032 Pixel buffer SHALL be sub-module raster_pix_fifo (sync FIFO, parametrised width/depth, full/empty flags).

Verification
REQ-033 Single pixel x=3,y=2,data=16'hABCD -> one write at addr 1283, we_n low 2 cycles, o_idle high again 3 cycles after pop.
REQ-034 FIFO_DEPTH=8, 12 pixels on consecutive cycles -> o_pix_ready drops when full, all 12 written in order, back-to-back 3-cycle writes, no gaps.
REQ-035 Pixel x=640,y=0 -> no SRAM write, o_drop_cnt=1, o_pix_ready stays high.
REQ-036 H_RES=4,V_RES=2, i_clear_start with 16'h0F0F -> addresses 0..7 written with 16'h0F0F, 24 write cycles, o_done one pulse, o_pix_ready low throughout.
REQ-037 rst asserted during WRITE -> we_n high and bus high-Z in same cycle, FIFO empty, o_drop_cnt=0 after release.
REQ-038 i_clear_start while FIFO holds 2 pixels -> ignored, 2 pixel writes only, no o_done.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared constants and FSM encoding for the raster SRAM writer.
package raster_pkg;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_RECOVER   = 3'd2,
        ST_CLEAR_WR  = 3'd3,
        ST_CLEAR_REC = 3'd4
    } wr_state_e;

    // Clear states block new pixels from entering the buffer.
    function automatic logic is_clear_state(wr_state_e s);
        return (s == ST_CLEAR_WR) || (s == ST_CLEAR_REC);
    endfunction

endpackage

// File: rtl/raster_pix_fifo.sv
// Synchronous show-ahead FIFO holding {addr, data} pixel writes.
module raster_pix_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW:0]                 wr_q, rd_q;
    logic                        do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Extra pointer bit separates the full and empty cases.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign dout_o  = mem_q[rd_q[PW-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/raster_sram_writer.sv
// Buffers pixel writes and drives them into an async SRAM, with a frame-fill mode.
module raster_sram_writer
    import raster_pkg::*;
#(
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 8,
    parameter int WAIT_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pix_valid,
    output logic              o_pix_ready,
    input  logic [9:0]        i_pix_x,
    input  logic [8:0]        i_pix_y,
    input  logic [DATA_W-1:0] i_pix_data,
    input  logic              i_clear_start,
    input  logic [DATA_W-1:0] i_clear_data,
    output logic              o_idle,
    output logic              o_done,
    output logic [15:0]       o_drop_cnt,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [DATA_W-1:0] io_sram_data,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n
);
    localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(H_RES * V_RES - 1);

    wr_state_e          state_q;
    logic [CNT_W-1:0]   wcnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic               we_n_q, drive_q, done_q, live_q;
    logic [15:0]        drop_q, drop_d;

    logic               accept, in_range, push, pop;
    logic [ADDR_W-1:0]  pix_addr, fifo_addr;
    logic [DATA_W-1:0]  fifo_data;
    logic [ADDR_W+DATA_W-1:0] fifo_dout;
    logic               fifo_full, fifo_empty;

    assign in_range = (32'(i_pix_x) < 32'(H_RES)) && (32'(i_pix_y) < 32'(V_RES));
    assign pix_addr = ADDR_W'(32'(i_pix_y) * 32'(H_RES) + 32'(i_pix_x));

    // live_q keeps ready/idle low until the first edge after reset release.
    assign o_pix_ready = live_q && !fifo_full && !is_clear_state(state_q);
    assign accept      = i_pix_valid && o_pix_ready;
    assign push        = accept && in_range;
    assign pop         = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_RECOVER));

    assign fifo_addr = fifo_dout[DATA_W +: ADDR_W];
    assign fifo_data = fifo_dout[DATA_W-1:0];

    raster_pix_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   ({pix_addr, i_pix_data}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign drop_d = (accept && !in_range && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

    // Saturating count of rejected out-of-frame pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_q <= '0;
        else      drop_q <= drop_d;
    end

    // Write sequencer: every SRAM cycle is WAIT_CYC strobe cycles plus one recovery cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= ST_WRITE;
                        addr_q  <= fifo_addr;
                        data_q  <= fifo_data;
                        we_n_q  <= 1'b0;
                        drive_q <= 1'b1;
                        wcnt_q  <= '0;
                    end else if (i_clear_start) begin
                        state_q <= ST_CLEAR_WR;
                        addr_q  <= '0;
                        data_q  <= i_clear_data;
                        we_n_q  <= 1'b0;
                        drive_q <= 1'b1;
                        wcnt_q  <= '0;
                    end
                end
                ST_WRITE, ST_CLEAR_WR: begin
                    if (wcnt_q == WAIT_LAST) begin
                        we_n_q  <= 1'b1;
                        state_q <= (state_q == ST_WRITE) ? ST_RECOVER : ST_CLEAR_REC;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (!fifo_empty) begin
                        state_q <= ST_WRITE;
                        addr_q  <= fifo_addr;
                        data_q  <= fifo_data;
                        we_n_q  <= 1'b0;
                        wcnt_q  <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                        drive_q <= 1'b0;
                    end
                end
                ST_CLEAR_REC: begin
                    if (addr_q == CLR_LAST) begin
                        state_q <= ST_IDLE;
                        drive_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_CLEAR_WR;
                        addr_q  <= addr_q + 1'b1;
                        we_n_q  <= 1'b0;
                        wcnt_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    we_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_idle       = live_q && fifo_empty && (state_q == ST_IDLE);
    assign o_done       = done_q;
    assign o_drop_cnt   = drop_q;
    assign o_sram_addr  = addr_q;
    assign o_sram_we_n  = we_n_q;
    assign o_sram_oe_n  = 1'b1;
    assign io_sram_data = drive_q ? data_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_raster_sram_writer.sv
// Directed bench: scoreboard of expected SRAM writes plus literal timing checks.
module tb_raster_sram_writer;

    logic        clk, rst;
    logic        pv, cs;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [15:0] pd, cd;
    logic        rdy, idle, done, we_n, oe_n;
    logic [15:0] drop;
    logic [19:0] addr;
    tri1  [15:0] bus;

    // small-frame instance used for the fill check
    logic        s_cs;
    logic [15:0] s_cd;
    logic        s_pv;
    logic [9:0]  s_px;
    logic [8:0]  s_py;
    logic [15:0] s_pd;
    logic        s_rdy, s_idle, s_done, s_we_n, s_oe_n;
    logic [15:0] s_drop;
    logic [19:0] s_addr;
    tri1  [15:0] s_bus;

    raster_sram_writer dut (
        .clk(clk), .rst(rst), .i_pix_valid(pv), .o_pix_ready(rdy),
        .i_pix_x(px), .i_pix_y(py), .i_pix_data(pd),
        .i_clear_start(cs), .i_clear_data(cd),
        .o_idle(idle), .o_done(done), .o_drop_cnt(drop),
        .o_sram_addr(addr), .io_sram_data(bus), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n)
    );

    raster_sram_writer #(.H_RES(4), .V_RES(2)) dut_s (
        .clk(clk), .rst(rst), .i_pix_valid(s_pv), .o_pix_ready(s_rdy),
        .i_pix_x(s_px), .i_pix_y(s_py), .i_pix_data(s_pd),
        .i_clear_start(s_cs), .i_clear_data(s_cd),
        .o_idle(s_idle), .o_done(s_done), .o_drop_cnt(s_drop),
        .o_sram_addr(s_addr), .io_sram_data(s_bus), .o_sram_we_n(s_we_n), .o_sram_oe_n(s_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [19:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          starts[$];
    logic [15:0] drop_model = 16'd0;
    int          nwrites = 0;
    int          stalls  = 0;

    // Drive one pixel and hold it until the handshake completes; records it in the model.
    task automatic send_pix(input int x, input int y, input logic [15:0] d, input logic clr);
        logic acc;
        int   w;
        wr_t  e;
        w   = 0;
        acc = 1'b0;
        while (!acc && w < 50) begin
            @(negedge clk);
            pv = 1'b1; px = 10'(x); py = 9'(y); pd = d; cs = clr;
            acc = rdy;
            if (!acc) stalls++;
            @(posedge clk);
            w++;
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL accept_timeout: got none want accept of x=%0d y=%0d", x, y);
        end else if (x < 640 && y < 480) begin
            e.a = 20'(y * 640 + x);
            e.d = d;
            exp_q.push_back(e);
        end else if (drop_model != 16'hFFFF) begin
            drop_model++;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || !idle) && w < 300) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("drain_in_time", 32'(w < 300), 32'd1);
    endtask

    // ---------------- per-cycle compare of the main instance ----------------
    wr_t cur;
    bit  have_cur = 0;
    int  run_len  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_we_n", 32'(we_n), 32'd1);
            chk("rst_oe_n", 32'(oe_n), 32'd1);
            chk("rst_bus_z", 32'(bus), 32'hFFFF);
            chk("rst_ready", 32'(rdy), 32'd0);
            chk("rst_idle", 32'(idle), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_drop", 32'(drop), 32'd0);
            chk("rst_addr", 32'(addr), 32'd0);
            run_len  = 0;
            have_cur = 0;
        end else begin
            chk("oe_n_high", 32'(oe_n), 32'd1);
            chk("no_done", 32'(done), 32'd0);
            chk("drop_cnt", 32'(drop), 32'(drop_model));
            if (!we_n) begin
                if (run_len == 0) begin
                    starts.push_back(cyc);
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        have_cur = 0;
                        $display("FAIL unexpected_write: got addr %0h want no write", addr);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                    end
                end
                if (have_cur) begin
                    chk("wr_addr", 32'(addr), 32'(cur.a));
                    chk("wr_data", 32'(bus), 32'(cur.d));
                end
                run_len++;
            end else if (run_len != 0) begin
                chk("we_low_len", 32'(run_len), 32'd2);
                if (have_cur) begin
                    chk("rec_addr_hold", 32'(addr), 32'(cur.a));
                    chk("rec_data_hold", 32'(bus), 32'(cur.d));
                end
                nwrites++;
                run_len = 0;
            end else if (idle) begin
                chk("idle_bus_z", 32'(bus), 32'hFFFF);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lowc, idle_k, nw0, w;
        rst = 1'b0; pv = 0; cs = 0; px = 0; py = 0; pd = 0; cd = 0;
        s_cs = 0; s_cd = 0; s_pv = 0; s_px = 0; s_py = 0; s_pd = 0;

        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(rdy), 32'd1);
        chk("post_rst_idle", 32'(idle), 32'd1);
        chk("post_rst_s_ready", 32'(s_rdy), 32'd1);

        // single pixel: addr 2*640+3, two strobe cycles, idle back 3 cycles after pop
        send_pix(3, 2, 16'hABCD, 1'b0);
        lowc = 0; idle_k = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) pv = 1'b0;
            if (!we_n) begin
                lowc++;
                if (k == 1) begin
                    chk("single_addr", 32'(addr), 32'd1283);
                    chk("single_data", 32'(bus), 32'hABCD);
                end
            end
            if (idle && idle_k < 0) idle_k = k;
        end
        chk("single_we_low_cycles", 32'(lowc), 32'd2);
        chk("single_idle_after", 32'(idle_k), 32'd4);

        // out-of-range column is dropped, ready stays high
        send_pix(640, 0, 16'h1234, 1'b0);
        @(negedge clk); pv = 1'b0;
        chk("drop_ready_high", 32'(rdy), 32'd1);
        chk("drop_cnt_one", 32'(drop), 32'd1);
        repeat (5) @(negedge clk);

        // frame corner accepted, row 480 dropped
        send_pix(639, 479, 16'h7E7E, 1'b0);
        send_pix(0, 480, 16'h1111, 1'b0);
        @(negedge clk); pv = 1'b0;
        drain();
        chk("drop_cnt_two", 32'(drop), 32'd2);

        // 12 pixels back to back: fills the buffer, writes every 3 cycles
        starts.delete();
        stalls = 0;
        for (int i = 0; i < 12; i++) send_pix(i, 5, 16'h1000 + 16'(i), 1'b0);
        @(negedge clk); pv = 1'b0;
        chk("burst_full_ready_low", 32'(rdy), 32'd0);
        chk("burst_no_stall", 32'(stalls), 32'd0);
        drain();
        chk("burst_write_count", 32'(starts.size()), 32'd12);
        for (int i = 1; i < starts.size(); i++)
            chk("burst_spacing", 32'(starts[i] - starts[i-1]), 32'd3);

        // clear request while pixels are pending is ignored
        nw0 = nwrites;
        send_pix(20, 7, 16'h2222, 1'b0);
        send_pix(21, 7, 16'h3333, 1'b1);
        @(negedge clk); pv = 1'b0; cs = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        chk("clear_ignored_writes", 32'(nwrites - nw0), 32'd2);

        // 4x2 frame fill on the small instance
        chk("s_pre_idle", 32'(s_idle), 32'd1);
        @(negedge clk); s_cs = 1'b1; s_cd = 16'h0F0F;
        @(negedge clk); s_cs = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 24) begin
                chk("fill_ready_low", 32'(s_rdy), 32'd0);
                chk("fill_we_n", 32'(s_we_n), 32'((k % 3) == 2));
                chk("fill_addr", 32'(s_addr), 32'(k / 3));
                chk("fill_data", 32'(s_bus), 32'h0F0F);
                chk("fill_done_low", 32'(s_done), 32'd0);
            end else begin
                chk("fill_done_pulse", 32'(s_done), 32'd1);
                chk("fill_idle", 32'(s_idle), 32'd1);
                chk("fill_ready_back", 32'(s_rdy), 32'd1);
                chk("fill_bus_z", 32'(s_bus), 32'hFFFF);
            end
        end
        @(negedge clk);
        chk("fill_done_single", 32'(s_done), 32'd0);

        // reset in the middle of a write
        send_pix(10, 1, 16'h5555, 1'b0);
        @(negedge clk); pv = 1'b0;
        w = 0;
        while (we_n && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("midwrite_reached", 32'(w < 20), 32'd1);
        #2 rst = 1'b0;
        exp_q.delete();
        drop_model = 16'd0;
        #1;
        chk("midrst_we_n", 32'(we_n), 32'd1);
        chk("midrst_bus_z", 32'(bus), 32'hFFFF);
        chk("midrst_ready", 32'(rdy), 32'd0);
        chk("midrst_idle", 32'(idle), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", 32'(rdy), 32'd1);
        chk("rel_idle", 32'(idle), 32'd1);
        chk("rel_drop", 32'(drop), 32'd0);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
